mux_4to1: RTL and testbench

Registered 4-to-1 selector. Routes one of four equal-width data inputs (i0..i3) to output y, chosen by the 2-bit selection_line. It is a generic datapath steering element, for example an operand or writeback source select in the CPU datapath. The output is registered once, in the clk domain, and carries a valid qualifier.

---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_4to1_comb.sv | 27 ++
 rtl/mux_4to1.sv | 61 ++++++
 tb/tb_mux_4to1.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared select encoding for the registered 4:1 selector.
package mux_pkg;

  // Two-bit select code: bit 1 is S1 (MSB), bit 0 is S0 (LSB).
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'b00;
  localparam sel_t SEL_I1 = 2'b01;
  localparam sel_t SEL_I2 = 2'b10;
  localparam sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux_4to1_comb.sv
// Purely combinational WIDTH-bit 4:1 data selector.
module mux_4to1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  sel_t             sel_i,
  output logic [WIDTH-1:0] sel_data_o
);

  // Full 2-bit decode; the leading default keeps the block latch-free.
  always_comb begin
    sel_data_o = '0;
    case (sel_i)
      SEL_I0: sel_data_o = i0;
      SEL_I1: sel_data_o = i1;
      SEL_I2: sel_data_o = i2;
      SEL_I3: sel_data_o = i3;
      default: sel_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mux_4to1.sv
// Registered 4:1 selector with a valid qualifier.
//
// Handshake: in_valid qualifies i0..i3 and selection_line in the cycle it is
// high; there is no ready, every qualified cycle is accepted. One cycle later
// y carries the selected data and y_valid is high for exactly that cycle.
// Cycles without in_valid leave y unchanged and drive y_valid low.
module mux_4to1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       selection_line,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;

  mux_4to1_comb #(.WIDTH(WIDTH)) u_comb (
    .i0         (i0),
    .i1         (i1),
    .i2         (i2),
    .i3         (i3),
    .sel_i      (sel_t'(selection_line)),
    .sel_data_o (sel_data)
  );

  // Next state: capture on a qualified cycle, otherwise hold data and drop valid.
  always_comb begin
    y_d       = y_q;
    y_valid_d = 1'b0;
    if (in_valid) begin
      y_d       = sel_data;
      y_valid_d = 1'b1;
    end
  end

  // Output register; synchronous reset wins over any qualified input.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1: directed scenarios at WIDTH 8 and WIDTH 1, then a
// randomized run checked against a behavioural model through an expected queue.
module tb_mux_4to1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       v8;
  logic [7:0] d8 [4];
  logic [1:0] s8;
  logic [7:0] y8;
  logic       yv8;

  logic       v1;
  logic       d1 [4];
  logic [1:0] s1;
  logic       y1;
  logic       yv1;

  int n_cmp = 0;
  int n_err = 0;

  // {valid, data} expected one cycle after the inputs that produce it
  logic [8:0] exp_q [$];
  logic [1:0] exp1_q [$];

  mux_4to1 #(.WIDTH(8)) dut8 (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (v8),
    .i0             (d8[0]),
    .i1             (d8[1]),
    .i2             (d8[2]),
    .i3             (d8[3]),
    .selection_line (s8),
    .y              (y8),
    .y_valid        (yv8)
  );

  mux_4to1 #(.WIDTH(1)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (v1),
    .i0             (d1[0]),
    .i1             (d1[1]),
    .i2             (d1[2]),
    .i3             (d1[3]),
    .selection_line (s1),
    .y              (y1),
    .y_valid        (yv1)
  );

  // ---------------- driver tasks ----------------
  // Inputs are set between edges; this advances one edge and settles 1 time unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [1:0] s,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    v8 = v; s8 = s;
    d8[0] = a; d8[1] = b; d8[2] = c; d8[3] = d;
  endtask

  task automatic idle1();
    v1 = 1'b0; s1 = 2'b00;
    for (int k = 0; k < 4; k++) d1[k] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    v1 = 1'b1; s1 = 2'b11;
    for (int k = 0; k < 4; k++) d1[k] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive8(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom));
      tick();
      n_cmp++;
      if (y8 !== 8'h00 || yv8 !== 1'b0) begin
        n_err++;
        $display("FAIL reset_w8 cyc%0d: got y=%h v=%b want y=00 v=0", c, y8, yv8);
      end
      n_cmp++;
      if (y1 !== 1'b0 || yv1 !== 1'b0) begin
        n_err++;
        $display("FAIL reset_w1 cyc%0d: got y=%b v=%b want y=0 v=0", c, y1, yv1);
      end
    end
    rst = 1'b0;
    idle1();
    drive8(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (yv8 !== 1'b0 || yv1 !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_idle cyc%0d: got v8=%b v1=%b want 0 0", c, yv8, yv1);
      end
    end
  endtask

  task automatic test_sweep_w1();
    logic exp_y [4];
    exp_y[0] = 1'b0; exp_y[1] = 1'b0; exp_y[2] = 1'b1; exp_y[3] = 1'b1;
    d1[0] = 1'b0; d1[1] = 1'b0; d1[2] = 1'b1; d1[3] = 1'b1;
    v1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s1 = 2'(k);
      tick();
      n_cmp++;
      if (y1 !== exp_y[k] || yv1 !== 1'b1) begin
        n_err++;
        $display("FAIL sweep_w1 sel=%0d: got y=%b v=%b want y=%b v=1", k, y1, yv1, exp_y[k]);
      end
    end
    idle1();
  endtask

  task automatic test_distinct();
    logic [1:0] sels [4];
    logic [7:0] exps [4];
    sels[0] = 2'b11; sels[1] = 2'b00; sels[2] = 2'b10; sels[3] = 2'b01;
    exps[0] = 8'hD3; exps[1] = 8'hA0; exps[2] = 8'hC2; exps[3] = 8'hB1;
    for (int k = 0; k < 4; k++) begin
      drive8(1'b1, sels[k], 8'hA0, 8'hB1, 8'hC2, 8'hD3);
      tick();
      n_cmp++;
      if (y8 !== exps[k] || yv8 !== 1'b1) begin
        n_err++;
        $display("FAIL distinct step%0d: got y=%h v=%b want y=%h v=1", k, y8, yv8, exps[k]);
      end
    end
  endtask

  task automatic test_hold();
    drive8(1'b1, 2'b10, 8'hA0, 8'hB1, 8'hC2, 8'hD3);
    tick();
    n_cmp++;
    if (y8 !== 8'hC2 || yv8 !== 1'b1) begin
      n_err++;
      $display("FAIL hold_capture: got y=%h v=%b want y=c2 v=1", y8, yv8);
    end
    for (int c = 0; c < 3; c++) begin
      drive8(1'b0, ~s8, ~d8[0], ~d8[1], ~d8[2], ~d8[3]);
      tick();
      n_cmp++;
      if (y8 !== 8'hC2 || yv8 !== 1'b0) begin
        n_err++;
        $display("FAIL hold cyc%0d: got y=%h v=%b want y=c2 v=0", c, y8, yv8);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive8(1'b1, 2'b11, 8'hA0, 8'hB1, 8'hC2, 8'hD3);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (y8 !== 8'h00 || yv8 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got y=%h v=%b want y=00 v=0", y8, yv8);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (y8 !== 8'hD3 || yv8 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_resume: got y=%h v=%b want y=d3 v=1", y8, yv8);
    end
  endtask

  task automatic test_comb_indep();
    logic [7:0] vals [2];
    vals[0] = 8'h11; vals[1] = 8'h22;
    for (int k = 0; k < 2; k++) begin
      drive8(1'b1, 2'b10, 8'hA0, 8'hB1, vals[k], 8'hD3);
      tick();
      n_cmp++;
      if (y8 !== vals[k] || yv8 !== 1'b1) begin
        n_err++;
        $display("FAIL comb_indep step%0d: got y=%h v=%b want y=%h v=1", k, y8, yv8, vals[k]);
      end
    end
  endtask

  // Random traffic; the model picks data[sel] on valid, keeps the last
  // value otherwise, and returns to zero on reset.
  task automatic test_random();
    logic [7:0] m_y8;
    logic       m_y1;
    logic [8:0] e8;
    logic [1:0] e1;
    rst = 1'b1;
    drive8(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    idle1();
    tick();
    m_y8 = 8'h00;
    m_y1 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 19) == 0);
      drive8(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      v1 = 1'($urandom_range(0, 1));
      s1 = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) d1[k] = 1'($urandom_range(0, 1));

      if (rst) begin
        m_y8 = 8'h00; m_y1 = 1'b0;
        exp_q.push_back({1'b0, 8'h00});
        exp1_q.push_back(2'b00);
      end else begin
        if (v8) m_y8 = d8[s8];
        if (v1) m_y1 = d1[s1];
        exp_q.push_back({v8, m_y8});
        exp1_q.push_back({v1, m_y1});
      end

      tick();
      e8 = exp_q.pop_front();
      e1 = exp1_q.pop_front();
      n_cmp++;
      if ({yv8, y8} !== e8) begin
        n_err++;
        $display("FAIL random_w8 cyc%0d: got v=%b y=%h want v=%b y=%h", c, yv8, y8, e8[8], e8[7:0]);
      end
      n_cmp++;
      if ({yv1, y1} !== e1) begin
        n_err++;
        $display("FAIL random_w1 cyc%0d: got v=%b y=%b want v=%b y=%b", c, yv1, y1, e1[1], e1[0]);
      end
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive8(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    idle1();
    #2;
    test_reset();
    test_sweep_w1();
    test_distinct();
    test_hold();
    test_reset_mid();
    test_comb_indep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
